// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch controller.
// The state encoding matches the 2-bit state port seen by the display logic.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StLap   = 2'd3
    } sw_state_e;

    localparam int unsigned DefClkHz  = 50_000_000;
    localparam int unsigned DefTickHz = 100;

    // Time advances in RUN and in LAP; LAP only freezes the display.
    function automatic logic is_counting(input sw_state_e s);
        return (s == StRun) || (s == StLap);
    endfunction

endpackage

// File: rtl/key_press_edge.sv
// Converts a debounced active-low key into a one-cycle press pulse.
// A key held down through reset never produces a press.
module key_press_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    // History holds the pressed level; resetting it to 1 treats the key as already
    // down, so it must be seen released before a press can be reported.
    logic down_q;
    logic down_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_q      <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            down_q      <= ~key;
            down_prev_q <= down_q;
        end
    end

    assign press = down_q & ~down_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with tick prescaler, clear and lap-hold outputs.
// Define STOPWATCH_LAP_EN to enable the LAP (frozen display) state.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DefClkHz,
    parameter int unsigned TICK_HZ = DefTickHz
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       lap_btn,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    localparam int unsigned Div    = CLK_HZ / TICK_HZ;
    localparam int unsigned PreW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);

    logic            start_press;
    logic            lap_press;
    sw_state_e       state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            clr_q, clr_d;
    logic            counting;

    key_press_edge u_start_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (start_btn),
        .press (start_press)
    );

    key_press_edge u_lap_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (lap_btn),
        .press (lap_press)
    );

    // Start always wins over a simultaneous lap press.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_press) begin
                    state_d = StRun;
                end else if (lap_press) begin
                    clr_d = 1'b1;
                end
            end
            StRun: begin
                if (start_press) begin
                    state_d = StPause;
`ifdef STOPWATCH_LAP_EN
                end else if (lap_press) begin
                    state_d = StLap;
`endif
                end
            end
            StPause: begin
                if (start_press) begin
                    state_d = StRun;
                end else if (lap_press) begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
                end
            end
            StLap: begin
`ifdef STOPWATCH_LAP_EN
                if (start_press) begin
                    state_d = StPause;
                end else if (lap_press) begin
                    state_d = StRun;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign counting = is_counting(state_q);

    // Prescaler keeps its phase while paused so no sub-tick time is lost.
    always_comb begin
        presc_d = presc_q;
        if (clr_d) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = (presc_q == PreMax) ? '0 : presc_q + PreW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            clr_q   <= clr_d;
        end
    end

    assign tick  = counting && (presc_q == PreMax);
    assign clr   = clr_q;
    assign state = state_q;

`ifdef STOPWATCH_LAP_EN
    assign hold = (state_q == StLap);
`else
    assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=400, TICK_HZ=100 (DIV=4).
// Covers the LAP state when STOPWATCH_LAP_EN is defined, lap-ignore otherwise.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       lap_btn;
    logic       tick;
    logic       clr;
    logic       hold;
    logic [1:0] state;

    int n_tests;
    int n_fail;
    int tick_cnt;
    int clr_cnt;
    int first_tick;

    stopwatch_ctrl #(
        .CLK_HZ  (400),
        .TICK_HZ (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .lap_btn   (lap_btn),
        .tick      (tick),
        .clr       (clr),
        .hold      (hold),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock, then sample just after the edge and tally pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (tick === 1'b1) tick_cnt++;
        if (clr === 1'b1) clr_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        tick_cnt  = 0;
        clr_cnt   = 0;
        rst_n     = 1'b0;
        start_btn = 1'b1;
        lap_btn   = 1'b1;

        // Reset state
        steps(3);
        check("rst_state", 32'(state), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_clr", 32'(clr), 0);
        check("rst_hold", 32'(hold), 0);
        rst_n = 1'b1;
        step();

        // Start press: state changes on the second edge after sampling low
        start_btn = 1'b0;
        step();
        check("start_edge1_state", 32'(state), 0);
        step();
        check("start_run_state", 32'(state), 1);
        check("run_p0_tick", 32'(tick), 0);

        // Key held 20 cycles: ticks on cycles 3,7,11,15,19, no second press
        tick_cnt   = 0;
        first_tick = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (tick === 1'b1 && first_tick == 0) first_tick = k;
        end
        check("first_tick_cycle", 32'(first_tick), 3);
        check("tick_count_20", 32'(tick_cnt), 5);
        check("held_key_state", 32'(state), 1);

        // Pause with prescaler=2 in the press cycle; phase advances to 3 then freezes
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        step();
        check("pause_state", 32'(state), 2);
        check("pause_tick", 32'(tick), 0);
        start_btn = 1'b1;
        tick_cnt  = 0;
        steps(10);
        check("pause_no_ticks", 32'(tick_cnt), 0);
        check("pause_still", 32'(state), 2);

        // Resume: retained phase 3 gives a tick in the first RUN cycle
        start_btn = 1'b0;
        step();
        step();
        check("resume_state", 32'(state), 1);
        check("resume_first_tick", 32'(tick), 1);
        start_btn = 1'b1;
        tick_cnt  = 0;
        steps(4);
        check("resume_period", 32'(tick_cnt), 1);
        check("resume_tick4", 32'(tick), 1);

`ifdef STOPWATCH_LAP_EN
        // Lap: display frozen, time keeps counting
        lap_btn = 1'b0;
        steps(2);
        check("lap_state", 32'(state), 3);
        check("lap_hold", 32'(hold), 1);
        lap_btn  = 1'b1;
        tick_cnt = 0;
        steps(8);
        check("lap_ticks", 32'(tick_cnt), 2);
        lap_btn = 1'b0;
        steps(2);
        check("unlap_state", 32'(state), 1);
        check("unlap_hold", 32'(hold), 0);
        lap_btn = 1'b1;
`else
        // Lap disabled: lap press in RUN is ignored
        lap_btn = 1'b0;
        steps(2);
        check("nolap_state", 32'(state), 1);
        check("nolap_hold", 32'(hold), 0);
        lap_btn  = 1'b1;
        tick_cnt = 0;
        steps(8);
        check("nolap_ticks", 32'(tick_cnt), 2);
`endif

        // Simultaneous start and lap in RUN: start wins, no clear
        clr_cnt   = 0;
        start_btn = 1'b0;
        lap_btn   = 1'b0;
        steps(2);
        check("simul_state", 32'(state), 2);
        check("simul_hold", 32'(hold), 0);
        start_btn = 1'b1;
        lap_btn   = 1'b1;
        step();
        check("simul_no_clr", 32'(clr_cnt), 0);

        // PAUSE lap: one-cycle clear, back to IDLE
        clr_cnt = 0;
        lap_btn = 1'b0;
        step();
        check("plap_edge1_clr", 32'(clr), 0);
        step();
        check("plap_state", 32'(state), 0);
        check("plap_clr", 32'(clr), 1);
        lap_btn = 1'b1;
        step();
        check("plap_clr_width", 32'(clr_cnt), 1);

        // IDLE lap: another clear, stays IDLE
        lap_btn = 1'b0;
        steps(2);
        check("ilap_clr", 32'(clr), 1);
        check("ilap_state", 32'(state), 0);
        lap_btn = 1'b1;
        step();
        check("ilap_clr_off", 32'(clr), 0);

        // Prescaler cleared: first tick again on the 4th RUN cycle
        start_btn = 1'b0;
        steps(2);
        check("restart_state", 32'(state), 1);
        start_btn = 1'b1;
        tick_cnt  = 0;
        steps(2);
        check("restart_no_early_tick", 32'(tick_cnt), 0);
        step();
        check("restart_tick", 32'(tick), 1);

        // Start key held through reset release: no transition
        rst_n     = 1'b0;
        start_btn = 1'b0;
        steps(2);
        check("rst2_state", 32'(state), 0);
        rst_n = 1'b1;
        steps(4);
        check("held_through_rst", 32'(state), 0);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        steps(2);
        check("post_rst_start", 32'(state), 1);
        start_btn = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, meaning count-enable rate (10 ms resolution); DIV = CLK_HZ/TICK_HZ, integer, >= 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start_btn  input  1  debounced start/stop key, active-low (0 = pressed).
REQ-006 SHALL have port lap_btn  input  1  debounced lap/reset key, active-low.
REQ-007 SHALL have port tick  output  1  one-cycle count-enable pulse to the digit counters.
REQ-008 SHALL have port clr  output  1  one-cycle synchronous clear to the digit counters.
REQ-009 SHALL have port hold  output  1  level; high freezes the displayed time (lap view).
REQ-010 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-011 SHALL detect a press as a registered 1->0 transition of each key, giving a one-cycle press pulse; holding a key produces exactly one press.
REQ-012 SHALL update state on the second rising clk edge after the key input is first sampled low.
REQ-013 SHALL implement states IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-014 SHALL in IDLE: start press -> RUN; lap press -> pulse clr, stay IDLE.
REQ-015 SHALL in RUN: start press -> PAUSE; lap press -> LAP.
REQ-016 SHALL in LAP: lap press -> RUN; start press -> PAUSE.
REQ-017 SHALL in PAUSE: start press -> RUN; lap press -> IDLE with one clr pulse.
REQ-018 SHALL, on simultaneous start and lap presses in the same cycle, act on start only and discard lap.
REQ-019 SHALL run a prescaler 0..DIV-1 that advances only in RUN or LAP and wraps to 0 from DIV-1.
REQ-020 SHALL assert tick for exactly one cycle when the prescaler is at DIV-1 in RUN or LAP; never in IDLE or PAUSE.
REQ-021 SHALL retain the prescaler value across PAUSE (no loss of sub-tick time); clear it to 0 on every clr pulse.
REQ-022 SHALL drive clr registered, high for exactly one cycle, in the cycle the transition takes effect; tick SHALL be 0 in that cycle.
REQ-023 SHALL drive hold = 1 exactly while state is LAP.

Reset
REQ-024 SHALL, when rst_n is sampled low, set state=IDLE, prescaler=0, tick=0, clr=0, hold=0.
REQ-025 SHALL, during reset, set key history registers to 1 so a key held through reset release produces no press.
REQ-026 SHALL abandon any operation on reset mid-RUN/LAP; the datapath is cleared by its own reset, not by clr.

Configuration
REQ-027 SHALL honour macro STOPWATCH_LAP_EN.
REQ-028 SHALL, with STOPWATCH_LAP_EN defined, implement LAP per REQ-015/016/023.
REQ-029 SHALL, without STOPWATCH_LAP_EN, make LAP unreachable: lap press in RUN ignored, hold tied 0; lap clear in IDLE/PAUSE unchanged.

Structure
REQ-030 SHALL place the state typedef (IDLE/RUN/PAUSE/LAP) and default CLK_HZ/TICK_HZ constants in shared package stopwatch_pkg.
REQ-031 SHALL use one sub-module, key_press_edge, instantiated per key, producing the press pulse of REQ-011.
REQ-032 SHALL size the prescaler to $clog2(DIV) bits.

Verification (bench uses CLK_HZ=400, TICK_HZ=100, DIV=4)
REQ-033 SHALL test: reset, start press, hold 20 cycles -> state 0->1, tick every 4th cycle, first tick 4 cycles after entering RUN, 4-5 ticks total.
REQ-034 SHALL test: RUN, start press with prescaler=2, wait 10, start press -> PAUSE with no ticks; after resume first tick after 1 cycle.
REQ-035 SHALL test: RUN, lap press -> state=3, hold=1, ticks continue; lap press -> state=1, hold=0.
REQ-036 SHALL test: PAUSE, lap press -> single-cycle clr, state=0, prescaler=0; IDLE lap press -> another clr, state stays 0.
REQ-037 SHALL test: start and lap falling on the same cycle in RUN -> state=2, hold=0, no clr.
REQ-038 SHALL test: start_btn held low through rst_n deassertion -> no transition; without STOPWATCH_LAP_EN, lap press in RUN -> state stays 1, hold=0.
